// File: rtl/uart_protocol_core.sv
// Full-duplex 8E1 UART endpoint: TX FIFO + serializer, synchronized RX deserializer + RX FIFO,
// with a strobe-based host bus and sticky/pulsed status flags.
module uart_protocol_core #(
   parameter int DATA_SIZE      = 8,
   parameter int SIZE_FIFO      = 8,
   parameter int CLKS_PER_BIT   = 16,
   parameter int BIT_COUNT_SIZE = $clog2(DATA_SIZE + 1)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 write_data,
   input  logic                 read_data,
   input  logic [DATA_SIZE-1:0] bus_data_in,
   output logic [DATA_SIZE-1:0] bus_data_out,
   input  logic                 serial_data_in,
   output logic                 serial_data_out,
   output logic [7:0]           TX_status_register,
   output logic [7:0]           RX_status_register
);

   localparam int AW = $clog2(SIZE_FIFO);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0]             LAST_CLK = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0]             HALF_CLK = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [BIT_COUNT_SIZE-1:0] LAST_BIT = BIT_COUNT_SIZE'(DATA_SIZE - 1);
   localparam logic [AW:0]               FULL_CNT = (AW + 1)'(SIZE_FIFO);

   typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} txState_t;
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rxState_t;

   // TX FIFO
   logic [DATA_SIZE-1:0] r_txMem [SIZE_FIFO];
   logic [AW:0]          r_txWrPtr, r_txRdPtr;
   logic [AW:0]          w_txCount;
   logic                 w_txEmpty, w_txFull, w_txPush, w_txPop;
   logic [DATA_SIZE-1:0] w_txHead;
   logic                 r_errorWriteData;

   assign w_txCount = r_txWrPtr - r_txRdPtr;
   assign w_txEmpty = (r_txWrPtr == r_txRdPtr);
   assign w_txFull  = (w_txCount == FULL_CNT);
   assign w_txPush  = write_data && !w_txFull;
   assign w_txHead  = r_txMem[r_txRdPtr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (w_txPush) r_txMem[r_txWrPtr[AW-1:0]] <= bus_data_in;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_txWrPtr        <= '0;
         r_txRdPtr        <= '0;
         r_errorWriteData <= 1'b0;
      end else begin
         if (w_txPush) r_txWrPtr <= r_txWrPtr + (AW + 1)'(1);
         if (w_txPop)  r_txRdPtr <= r_txRdPtr + (AW + 1)'(1);
         r_errorWriteData <= write_data && w_txFull;
      end
   end

   // TX serializer
   txState_t                r_txState, w_txStateNext;
   logic [CW-1:0]           r_txClk, w_txClkNext;
   logic [BIT_COUNT_SIZE-1:0] r_txBit, w_txBitNext;
   logic [DATA_SIZE-1:0]    r_txShift, w_txShiftNext;
   logic                    r_txParity, w_txParityNext;
   logic                    r_txLine, w_txLineNext;
   logic                    w_txLoad, w_txTick;

   assign w_txTick = (r_txClk == LAST_CLK);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_txState  <= TX_IDLE;
         r_txClk    <= '0;
         r_txBit    <= '0;
         r_txShift  <= '0;
         r_txParity <= 1'b0;
         r_txLine   <= 1'b1;
      end else begin
         r_txState  <= w_txStateNext;
         r_txClk    <= w_txClkNext;
         r_txBit    <= w_txBitNext;
         r_txShift  <= w_txShiftNext;
         r_txParity <= w_txParityNext;
         r_txLine   <= w_txLineNext;
      end
   end

   always_comb begin
      w_txStateNext  = r_txState;
      w_txClkNext    = r_txClk;
      w_txBitNext    = r_txBit;
      w_txShiftNext  = r_txShift;
      w_txParityNext = r_txParity;
      w_txLineNext   = r_txLine;
      w_txLoad       = 1'b0;
      w_txPop        = 1'b0;
      case (r_txState)
         TX_IDLE: begin
            w_txLineNext = 1'b1;
            if (!w_txEmpty) w_txLoad = 1'b1;
         end
         TX_START: begin
            w_txClkNext = r_txClk + CW'(1);
            if (w_txTick) begin
               w_txClkNext   = '0;
               w_txBitNext   = '0;
               w_txStateNext = TX_DATA;
               w_txLineNext  = r_txShift[0];
            end
         end
         TX_DATA: begin
            w_txClkNext = r_txClk + CW'(1);
            if (w_txTick) begin
               w_txClkNext = '0;
               if (r_txBit == LAST_BIT) begin
                  w_txStateNext = TX_PARITY;
                  w_txLineNext  = r_txParity;
               end else begin
                  w_txBitNext   = r_txBit + BIT_COUNT_SIZE'(1);
                  w_txShiftNext = {1'b0, r_txShift[DATA_SIZE-1:1]};
                  w_txLineNext  = r_txShift[1];
               end
            end
         end
         TX_PARITY: begin
            w_txClkNext = r_txClk + CW'(1);
            if (w_txTick) begin
               w_txClkNext   = '0;
               w_txStateNext = TX_STOP;
               w_txLineNext  = 1'b1;
            end
         end
         TX_STOP: begin
            w_txClkNext = r_txClk + CW'(1);
            if (w_txTick) begin
               w_txClkNext   = '0;
               w_txStateNext = TX_IDLE;
               w_txLineNext  = 1'b1;
               if (!w_txEmpty) w_txLoad = 1'b1;
            end
         end
         default: begin
            w_txStateNext = TX_IDLE;
            w_txLineNext  = 1'b1;
         end
      endcase
      // Loading from STOP chains frames with no idle gap on the line
      if (w_txLoad) begin
         w_txPop        = 1'b1;
         w_txShiftNext  = w_txHead;
         w_txParityNext = ^w_txHead;
         w_txStateNext  = TX_START;
         w_txLineNext   = 1'b0;
         w_txClkNext    = '0;
      end
   end

   assign serial_data_out = r_txLine;

   // RX synchronizer and deserializer
   logic r_rxSync1, r_rxSync2, r_rxPrev;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rxSync1 <= 1'b1;
         r_rxSync2 <= 1'b1;
         r_rxPrev  <= 1'b1;
      end else begin
         r_rxSync1 <= serial_data_in;
         r_rxSync2 <= r_rxSync1;
         r_rxPrev  <= r_rxSync2;
      end
   end

   rxState_t                  r_rxState, w_rxStateNext;
   logic [CW-1:0]             r_rxClk, w_rxClkNext;
   logic [BIT_COUNT_SIZE-1:0] r_rxBit, w_rxBitNext;
   logic [DATA_SIZE-1:0]      r_rxShift, w_rxShiftNext;
   logic                      r_rxParityBit, w_rxParityBitNext;
   logic                      w_rxDone, w_rxTick, w_rxBreak;

   assign w_rxTick  = (r_rxClk == LAST_CLK);
   assign w_rxBreak = (r_rxShift == '0) && !r_rxParityBit && !r_rxSync2;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rxState     <= RX_IDLE;
         r_rxClk       <= '0;
         r_rxBit       <= '0;
         r_rxShift     <= '0;
         r_rxParityBit <= 1'b0;
      end else begin
         r_rxState     <= w_rxStateNext;
         r_rxClk       <= w_rxClkNext;
         r_rxBit       <= w_rxBitNext;
         r_rxShift     <= w_rxShiftNext;
         r_rxParityBit <= w_rxParityBitNext;
      end
   end

   always_comb begin
      w_rxStateNext     = r_rxState;
      w_rxClkNext       = r_rxClk + CW'(1);
      w_rxBitNext       = r_rxBit;
      w_rxShiftNext     = r_rxShift;
      w_rxParityBitNext = r_rxParityBit;
      w_rxDone          = 1'b0;
      case (r_rxState)
         RX_IDLE: begin
            w_rxClkNext = '0;
            if (r_rxPrev && !r_rxSync2) w_rxStateNext = RX_START;
         end
         RX_START: begin
            // A start bit that is high again at mid-bit was a glitch
            if (r_rxClk == HALF_CLK) begin
               w_rxClkNext   = '0;
               w_rxBitNext   = '0;
               w_rxStateNext = r_rxSync2 ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (w_rxTick) begin
               w_rxClkNext   = '0;
               w_rxShiftNext = {r_rxSync2, r_rxShift[DATA_SIZE-1:1]};
               if (r_rxBit == LAST_BIT) w_rxStateNext = RX_PARITY;
               else                     w_rxBitNext   = r_rxBit + BIT_COUNT_SIZE'(1);
            end
         end
         RX_PARITY: begin
            if (w_rxTick) begin
               w_rxClkNext       = '0;
               w_rxParityBitNext = r_rxSync2;
               w_rxStateNext     = RX_STOP;
            end
         end
         RX_STOP: begin
            if (w_rxTick) begin
               w_rxClkNext   = '0;
               w_rxDone      = 1'b1;
               w_rxStateNext = RX_IDLE;
            end
         end
         default: begin
            w_rxClkNext   = '0;
            w_rxStateNext = RX_IDLE;
         end
      endcase
   end

   // RX FIFO, error flags and host read port
   logic [DATA_SIZE-1:0] r_rxMem [SIZE_FIFO];
   logic [AW:0]          r_rxWrPtr, r_rxRdPtr;
   logic [AW:0]          w_rxCount;
   logic                 w_rxEmpty, w_rxFull, w_rxPush, w_rxPop;
   logic                 r_parityError, r_breakError, r_stopError, r_overflowError, r_readNotReady;

   assign w_rxCount = r_rxWrPtr - r_rxRdPtr;
   assign w_rxEmpty = (r_rxWrPtr == r_rxRdPtr);
   assign w_rxFull  = (w_rxCount == FULL_CNT);
   assign w_rxPop   = read_data && !w_rxEmpty;
   assign w_rxPush  = w_rxDone && (!w_rxFull || w_rxPop);

   always_ff @(posedge clk) begin
      if (w_rxPush) r_rxMem[r_rxWrPtr[AW-1:0]] <= r_rxShift;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rxWrPtr       <= '0;
         r_rxRdPtr       <= '0;
         bus_data_out    <= '0;
         r_parityError   <= 1'b0;
         r_breakError    <= 1'b0;
         r_stopError     <= 1'b0;
         r_overflowError <= 1'b0;
         r_readNotReady  <= 1'b0;
      end else begin
         if (w_rxPush) r_rxWrPtr <= r_rxWrPtr + (AW + 1)'(1);
         if (w_rxPop) begin
            r_rxRdPtr    <= r_rxRdPtr + (AW + 1)'(1);
            bus_data_out <= r_rxMem[r_rxRdPtr[AW-1:0]];
         end
         if (w_rxDone) begin
            r_parityError <= (r_rxParityBit != ^r_rxShift);
            r_breakError  <= w_rxBreak;
            r_stopError   <= !r_rxSync2 && !w_rxBreak;
         end
         if (w_rxDone && w_rxFull && !w_rxPop) r_overflowError <= 1'b1;
         else if (w_rxPop)                     r_overflowError <= 1'b0;
         r_readNotReady <= read_data && w_rxEmpty;
      end
   end

   assign TX_status_register = {5'b0, w_txEmpty, w_txFull, r_errorWriteData};
   assign RX_status_register = {r_readNotReady, r_overflowError, r_stopError, r_breakError,
                                r_parityError, w_rxEmpty, w_rxFull, 1'b0};

endmodule

// File: tb/tb_uart_protocol_core.sv
// Two looped UART cores; core 2's RX line can be switched to a bench-driven injector
// for malformed frames. Received bytes are checked against a queue of expected data.
module tb_uart_protocol_core;

   localparam int CPB   = 4;
   localparam int DEPTH = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic       writeData1, readData1, writeData2, readData2;
   logic [7:0] busIn1, busIn2, busOut1, busOut2;
   logic       line12, line21, rxIn2, injLine, injectMode;
   logic [7:0] txStat1, rxStat1, txStat2, rxStat2;

   assign rxIn2 = injectMode ? injLine : line12;

   uart_protocol_core #(.DATA_SIZE(8), .SIZE_FIFO(DEPTH), .CLKS_PER_BIT(CPB)) core1 (
      .clk(clk), .reset(reset), .write_data(writeData1), .read_data(readData1),
      .bus_data_in(busIn1), .bus_data_out(busOut1), .serial_data_in(line21),
      .serial_data_out(line12), .TX_status_register(txStat1), .RX_status_register(rxStat1));

   uart_protocol_core #(.DATA_SIZE(8), .SIZE_FIFO(DEPTH), .CLKS_PER_BIT(CPB)) core2 (
      .clk(clk), .reset(reset), .write_data(writeData2), .read_data(readData2),
      .bus_data_in(busIn2), .bus_data_out(busOut2), .serial_data_in(rxIn2),
      .serial_data_out(line21), .TX_status_register(txStat2), .RX_status_register(rxStat2));

   typedef struct {
      logic [7:0] data;
      logic       parity;
      logic       stop;
      logic       expParity;
      logic       expBreak;
      logic       expStop;
   } frameVec_t;

   int         checks   = 0;
   int         failures = 0;
   logic [7:0] expQ[$];
   logic [7:0] lastRead;
   frameVec_t  vecs[7];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic timeoutFail(input string name);
      checks++;
      failures++;
      $display("[TB] FAIL %s: timed out waiting for DUT", name);
   endtask

   task automatic writeCore1(input logic [7:0] d);
      @(negedge clk);
      writeData1 = 1'b1;
      busIn1     = d;
      @(negedge clk);
      writeData1 = 1'b0;
   endtask

   task automatic readCore2();
      @(negedge clk);
      readData2 = 1'b1;
      @(negedge clk);
      readData2 = 1'b0;
   endtask

   task automatic waitRx2(input string name, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (!rxStat2[2]) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) timeoutFail(name);
   endtask

   task automatic readAndCompare(input string name);
      bit         ok;
      logic [7:0] exp;
      waitRx2(name, ok);
      if (ok) begin
         readCore2();
         if (expQ.size() == 0) begin
            timeoutFail({name, " (no expected data)"});
         end else begin
            exp = expQ.pop_front();
            checkOutput(name, {24'b0, busOut2}, {24'b0, exp});
            lastRead = exp;
         end
      end
   endtask

   task automatic injectFrame(input logic [7:0] d, input logic par, input logic stp);
      logic [10:0] bits;
      bits = {stp, par, d, 1'b0};
      for (int b = 0; b < 11; b++) begin
         @(negedge clk);
         injLine = bits[b];
         repeat (CPB - 1) @(negedge clk);
      end
      @(negedge clk);
      injLine = 1'b1;
      repeat (3 * CPB) @(negedge clk);
   endtask

   task automatic applyStimulus(input frameVec_t v, input int idx);
      bit ok;
      injectFrame(v.data, v.parity, v.stop);
      expQ.push_back(v.data);
      waitRx2($sformatf("vec%0d arrival", idx), ok);
      if (ok) begin
         checkOutput($sformatf("vec%0d parity_error", idx), rxStat2[3], v.expParity);
         checkOutput($sformatf("vec%0d break_error", idx), rxStat2[4], v.expBreak);
         checkOutput($sformatf("vec%0d stop_error", idx), rxStat2[5], v.expStop);
      end
      readAndCompare($sformatf("vec%0d data", idx));
   endtask

   initial begin
      logic [10:0] a5Bits;
      logic [7:0]  d;

      vecs[0] = '{8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[1] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[2] = '{8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[3] = '{8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[4] = '{8'h80, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[5] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[6] = '{8'h7F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

      reset      = 1'b1;
      writeData1 = 1'b0;
      readData1  = 1'b0;
      writeData2 = 1'b0;
      readData2  = 1'b0;
      busIn1     = 8'h00;
      busIn2     = 8'h00;
      injLine    = 1'b1;
      injectMode = 1'b0;
      lastRead   = 8'h00;

      // Reset state
      repeat (3) @(negedge clk);
      checkOutput("reset line1", line12, 1'b1);
      checkOutput("reset line2", line21, 1'b1);
      checkOutput("reset busOut2", busOut2, 8'h00);
      checkOutput("reset txStat1", txStat1, 8'h04);
      checkOutput("reset rxStat2", rxStat2, 8'h04);
      reset = 1'b0;
      @(negedge clk);
      checkOutput("post-reset rxStat1", rxStat1, 8'h04);
      checkOutput("post-reset txStat2", txStat2, 8'h04);
      checkOutput("post-reset busOut1", busOut1, 8'h00);

      // 8'hA5 frame bit by bit on the line, then through core 2
      a5Bits = {1'b1, ^8'hA5, 8'hA5, 1'b0};
      writeCore1(8'hA5);
      expQ.push_back(8'hA5);
      checkOutput("a5 line idle before start", line12, 1'b1);
      for (int b = 0; b < 11; b++) begin
         for (int c = 0; c < CPB; c++) begin
            @(negedge clk);
            checkOutput($sformatf("a5 bit%0d cyc%0d", b, c), line12, a5Bits[b]);
         end
      end
      readAndCompare("a5 data");
      checkOutput("a5 error bits", rxStat2[6:3], 4'h0);

      // Fill the TX FIFO while the first word is already being sent
      repeat (20) @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (i == 8) checkOutput("tx not full at 7", txStat1[1], 1'b0);
         if (i == 9) checkOutput("tx full", txStat1[1], 1'b1);
         d          = 8'(i * 37 + 11);
         writeData1 = 1'b1;
         busIn1     = d;
         if (i < 9) expQ.push_back(d);
      end
      @(negedge clk);
      writeData1 = 1'b0;
      checkOutput("write error pulse", txStat1[0], 1'b1);
      @(negedge clk);
      checkOutput("write error clears", txStat1[0], 1'b0);
      for (int k = 0; k < 9; k++) readAndCompare($sformatf("burst data%0d", k));
      repeat (120) @(negedge clk);
      checkOutput("dropped word never sent", rxStat2[2], 1'b1);
      checkOutput("tx drained", txStat1[2], 1'b1);

      // Read from an empty RX FIFO
      @(negedge clk);
      readData2 = 1'b1;
      @(negedge clk);
      readData2 = 1'b0;
      checkOutput("read not ready pulse", rxStat2[7], 1'b1);
      checkOutput("busOut2 held", busOut2, lastRead);
      @(negedge clk);
      checkOutput("read not ready clears", rxStat2[7], 1'b0);

      // Injected frames with line errors
      injectMode = 1'b1;
      for (int i = 0; i < 7; i++) applyStimulus(vecs[i], i);

      // RX overflow: one frame more than the FIFO holds
      for (int i = 0; i <= DEPTH; i++) begin
         d = 8'(8'h30 + i * 7);
         injectFrame(d, ^d, 1'b1);
         if (i < DEPTH) expQ.push_back(d);
         if (i == DEPTH - 1) begin
            checkOutput("rx full at depth", rxStat2[1], 1'b1);
            checkOutput("no overflow at depth", rxStat2[6], 1'b0);
         end
      end
      checkOutput("rx full after overflow", rxStat2[1], 1'b1);
      checkOutput("overflow set", rxStat2[6], 1'b1);
      for (int k = 0; k < DEPTH; k++) begin
         readAndCompare($sformatf("overflow data%0d", k));
         if (k == 0) checkOutput("overflow cleared by read", rxStat2[6], 1'b0);
      end
      @(negedge clk);
      checkOutput("rx empty after drain", rxStat2[2], 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
